// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD converter.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_e;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);
  always_comb begin
    o_digit = i_digit;
    if (i_digit >= ADD3_THRESH) o_digit = i_digit + 4'd3;
  end
endmodule

// File: rtl/bcd_converter_pro.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one magnitude bit per cycle.
// Optional per-digit leading-zero mask o_Blank is built only with BCD_LZ_BLANK_EN.
module bcd_converter_pro
  import bcd_pkg::*;
#(
  parameter int INPUT_WIDTH    = 8,
  parameter int DECIMAL_DIGITS = 3,
  parameter int SIGNED         = 0
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic [INPUT_WIDTH-1:0]    i_Binary,
  input  logic                      i_Start,
  output logic [DECIMAL_DIGITS*4-1:0] o_BCD,
  output logic                      o_Sign,
  output logic                      o_Overflow,
  output logic                      o_DV,
  output logic                      o_Busy
`ifdef BCD_LZ_BLANK_EN
  ,
  output logic [DECIMAL_DIGITS-1:0] o_Blank
`endif
);
  localparam int BCD_W = DECIMAL_DIGITS * BCD_DIGIT_W;
  localparam int CNT_W = $clog2(INPUT_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INPUT_WIDTH - 1);

  bcd_state_e             state_q, state_d;
  logic [INPUT_WIDTH-1:0] mag_q, mag_d;
  logic [BCD_W-1:0]       work_q, work_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   neg_q, neg_d;
  logic                   ovf_acc_q, ovf_acc_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic                   sign_q, sign_d;
  logic                   ovf_q, ovf_d;
  logic                   dv_q, dv_d;
  logic                   busy_q, busy_d;

  logic [BCD_W-1:0]       adj;
  logic [BCD_W-1:0]       shifted;
  logic                   carry;
  logic                   in_neg;
  logic [INPUT_WIDTH-1:0] in_mag;

  for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Any bit leaving the top digit is a multiple of 10^DECIMAL_DIGITS: flag it.
  assign carry   = adj[BCD_W-1];
  assign shifted = {adj[BCD_W-2:0], mag_q[INPUT_WIDTH-1]};

  // Negation in INPUT_WIDTH bits keeps the most negative value exact as unsigned.
  assign in_neg = (SIGNED != 0) && i_Binary[INPUT_WIDTH-1];
  assign in_mag = in_neg ? ((~i_Binary) + {{(INPUT_WIDTH-1){1'b0}}, 1'b1}) : i_Binary;

`ifdef BCD_LZ_BLANK_EN
  logic [DECIMAL_DIGITS-1:0] blank_q, blank_d, blank_nx;
  logic                      upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    blank_nx   = '0;
    for (int k = DECIMAL_DIGITS - 1; k >= 0; k--) begin
      upper_zero  = upper_zero & (shifted[k*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      blank_nx[k] = (k > 0) && upper_zero;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    ovf_acc_d = ovf_acc_q;
    bcd_d     = bcd_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    dv_d      = 1'b0;
    busy_d    = busy_q;
`ifdef BCD_LZ_BLANK_EN
    blank_d   = blank_q;
`endif
    case (state_q)
      SHIFT: begin
        mag_d     = mag_q << 1;
        work_d    = shifted;
        ovf_acc_d = ovf_acc_q | carry;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          busy_d  = 1'b0;
          dv_d    = 1'b1;
          bcd_d   = shifted;
          ovf_d   = ovf_acc_q | carry;
          sign_d  = neg_q;
`ifdef BCD_LZ_BLANK_EN
          blank_d = blank_nx;
`endif
        end
      end
      default: begin
        if (state_q == DONE) state_d = IDLE;
        if (i_Start) begin
          state_d   = SHIFT;
          mag_d     = in_mag;
          neg_d     = in_neg;
          work_d    = '0;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef BCD_LZ_BLANK_EN
      blank_q   <= '1;
`endif
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      ovf_acc_q <= ovf_acc_d;
      bcd_q     <= bcd_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
      dv_q      <= dv_d;
      busy_q    <= busy_d;
`ifdef BCD_LZ_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign o_BCD      = bcd_q;
  assign o_Sign     = sign_q;
  assign o_Overflow = ovf_q;
  assign o_DV       = dv_q;
  assign o_Busy     = busy_q;
`ifdef BCD_LZ_BLANK_EN
  assign o_Blank    = blank_q;
`endif
endmodule

// File: tb/tb_bcd_converter_pro.sv
// Directed bench for bcd_converter_pro: three configurations sharing one clock and reset.
module tb_bcd_converter_pro;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // u0: W=5 D=2 unsigned; u1: W=5 D=1 unsigned; u2: W=8 D=3 signed
  logic [4:0]  bin0, bin1;
  logic [7:0]  bin2;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [7:0]  bcd0;
  logic [3:0]  bcd1;
  logic [11:0] bcd2;
  logic        sign0, sign1, sign2, ovf0, ovf1, ovf2, dv0, dv1, dv2, busy0, busy1, busy2;
`ifdef BCD_LZ_BLANK_EN
  logic [1:0]  blank0;
  logic [0:0]  blank1;
  logic [2:0]  blank2;
`endif

  bcd_converter_pro #(.INPUT_WIDTH(5), .DECIMAL_DIGITS(2), .SIGNED(0)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_Binary(bin0), .i_Start(start0),
    .o_BCD(bcd0), .o_Sign(sign0), .o_Overflow(ovf0), .o_DV(dv0), .o_Busy(busy0)
`ifdef BCD_LZ_BLANK_EN
    , .o_Blank(blank0)
`endif
  );

  bcd_converter_pro #(.INPUT_WIDTH(5), .DECIMAL_DIGITS(1), .SIGNED(0)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_Binary(bin1), .i_Start(start1),
    .o_BCD(bcd1), .o_Sign(sign1), .o_Overflow(ovf1), .o_DV(dv1), .o_Busy(busy1)
`ifdef BCD_LZ_BLANK_EN
    , .o_Blank(blank1)
`endif
  );

  bcd_converter_pro #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(3), .SIGNED(1)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_Binary(bin2), .i_Start(start2),
    .o_BCD(bcd2), .o_Sign(sign2), .o_Overflow(ovf2), .o_DV(dv2), .o_Busy(busy2)
`ifdef BCD_LZ_BLANK_EN
    , .o_Blank(blank2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k counts falling edges after the accept edge; the result lands after the 5th shift edge.
  // A second start with a different value is raised mid-SHIFT and must be ignored.
  task automatic conv0(input logic [4:0] b, input logic [7:0] exp_bcd, input string tag);
    bin0 = b; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      chk({tag, ".dv"}, dv0, k == 5);
      chk({tag, ".busy"}, busy0, k < 5);
      if (k == 2) begin start0 = 1'b1; bin0 = ~b; end
      if (k == 3) start0 = 1'b0;
      if (k == 5) begin
        chk({tag, ".bcd"}, bcd0, exp_bcd);
        chk({tag, ".ovf"}, ovf0, 1'b0);
        chk({tag, ".sign"}, sign0, 1'b0);
      end
      if (k == 6) chk({tag, ".hold"}, bcd0, exp_bcd);
      if (k < 6) @(negedge clk);
    end
  endtask

  task automatic conv2(input logic [7:0] b, input logic [11:0] exp_bcd, input logic exp_sign,
                       input logic [2:0] exp_blank, input string tag);
    bin2 = b; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      chk({tag, ".dv"}, dv2, k == 8);
      if (k == 8) begin
        chk({tag, ".bcd"}, bcd2, exp_bcd);
        chk({tag, ".sign"}, sign2, exp_sign);
        chk({tag, ".ovf"}, ovf2, 1'b0);
`ifdef BCD_LZ_BLANK_EN
        chk({tag, ".blank"}, blank2, exp_blank);
`else
        chk({tag, ".busy"}, busy2, exp_blank[2] & 1'b0);
`endif
      end
      if (k < 9) @(negedge clk);
    end
  endtask

  initial begin
    bool_dummy();
  end

  function automatic void bool_dummy();
  endfunction

  initial begin
    logic dv_seen;
    bin0 = '0; bin1 = '0; bin2 = '0;
    repeat (2) @(negedge clk);
    chk("rst.bcd0", bcd0, 8'h00);
    chk("rst.dv0", dv0, 1'b0);
    chk("rst.busy0", busy0, 1'b0);
    chk("rst.ovf0", ovf0, 1'b0);
    chk("rst.sign2", sign2, 1'b0);
`ifdef BCD_LZ_BLANK_EN
    chk("rst.blank2", blank2, 3'b111);
`endif
    rst = 1'b0;
    @(negedge clk);

    conv0(5'd23, 8'h23, "single23");

    // start held high: back-to-back results every 6 cycles, busy low only in DONE
    bin0 = 5'd31; start0 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      chk("b2b.dv", dv0, (k % 6) == 5);
      chk("b2b.busy", busy0, (k % 6) != 5);
      if ((k % 6) == 5) chk("b2b.bcd", bcd0, 8'h31);
      if (k < 17) @(negedge clk);
    end
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b.idle", busy0, 1'b0);

    // overflow: 23 into one digit keeps 23 mod 10
    bin1 = 5'd23; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      chk("ovf.dv", dv1, k == 5);
      if (k == 5) begin
        chk("ovf.bcd", bcd1, 4'h3);
        chk("ovf.flag", ovf1, 1'b1);
        chk("ovf.sign", sign1, 1'b0);
      end
      if (k < 5) @(negedge clk);
    end

    conv2(8'h80, 12'h128, 1'b1, 3'b000, "neg128");
    conv2(8'hFF, 12'h001, 1'b1, 3'b110, "neg1");
    conv2(8'd100, 12'h100, 1'b0, 3'b000, "pos100");
    conv2(8'd7, 12'h007, 1'b0, 3'b110, "pos7");
    conv2(8'd0, 12'h000, 1'b0, 3'b110, "zero");

    // reset during SHIFT with start held: no result, reset values, then a clean conversion
    bin0 = 5'd23; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; start0 = 1'b1;
    @(negedge clk);
    chk("abort.dv", dv0, 1'b0);
    chk("abort.busy", busy0, 1'b0);
    chk("abort.bcd", bcd0, 8'h00);
    chk("abort.ovf", ovf0, 1'b0);
    chk("abort.sign", sign0, 1'b0);
    rst = 1'b0; start0 = 1'b0;
    dv_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dv_seen = dv_seen | dv0 | busy0;
    end
    chk("abort.quiet", dv_seen, 1'b0);
    conv0(5'd17, 8'h17, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
